// File: rtl/cmult_scheduler.sv
// cmult_scheduler: round-robin arbiter sharing one fixed-latency complex multiplier
// between two requesters, with a tag pipeline routing each result back to its owner.
module cmult_scheduler #(
  parameter int DATAWIDTH = 16,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_re_a,
  input  logic [DATAWIDTH-1:0] req0_im_a,
  input  logic [DATAWIDTH-1:0] req0_re_b,
  input  logic [DATAWIDTH-1:0] req0_im_b,
  input  logic                 req0_conj,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_re_a,
  input  logic [DATAWIDTH-1:0] req1_im_a,
  input  logic [DATAWIDTH-1:0] req1_re_b,
  input  logic [DATAWIDTH-1:0] req1_im_b,
  input  logic                 req1_conj,
  output logic [DATAWIDTH-1:0] mul_re_a,
  output logic [DATAWIDTH-1:0] mul_im_a,
  output logic [DATAWIDTH-1:0] mul_re_b,
  output logic [DATAWIDTH-1:0] mul_im_b,
  output logic                 mul_conj,
  input  logic [DATAWIDTH-1:0] mul_re_i,
  input  logic [DATAWIDTH-1:0] mul_im_i,
  output logic                 res0_valid,
  output logic [DATAWIDTH-1:0] res0_re,
  output logic [DATAWIDTH-1:0] res0_im,
  output logic                 res1_valid,
  output logic [DATAWIDTH-1:0] res1_re,
  output logic [DATAWIDTH-1:0] res1_im,
  output logic                 busy,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
);
  localparam int W = DATAWIDTH;
  localparam int S = LATENCY + 1;
  logic         gnt0, gnt1, xfer;
  logic         ptr_q, ptr_d;
  logic [W-1:0] mul_re_a_q, mul_re_a_d, mul_im_a_q, mul_im_a_d;
  logic [W-1:0] mul_re_b_q, mul_re_b_d, mul_im_b_q, mul_im_b_d;
  logic         mul_conj_q, mul_conj_d;
  logic [S-1:0] tv_q, tv_d, tid_q, tid_d;
  logic         res0_valid_q, res0_valid_d, res1_valid_q, res1_valid_d;
  logic [W-1:0] res0_re_q, res0_re_d, res0_im_q, res0_im_d;
  logic [W-1:0] res1_re_q, res1_re_d, res1_im_q, res1_im_d;
  logic [15:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  // ptr_q=0 favours requester 0 on contention; it moves past whoever was just served
  always_comb begin
    gnt0         = rst_n & sched_en & req0_valid & (~req1_valid | ~ptr_q);
    gnt1         = rst_n & sched_en & req1_valid & (~req0_valid | ptr_q);
    xfer         = gnt0 | gnt1;
    ptr_d        = xfer ? gnt0 : ptr_q;
    mul_re_a_d   = gnt0 ? req0_re_a : gnt1 ? req1_re_a : '0;
    mul_im_a_d   = gnt0 ? req0_im_a : gnt1 ? req1_im_a : '0;
    mul_re_b_d   = gnt0 ? req0_re_b : gnt1 ? req1_re_b : '0;
    mul_im_b_d   = gnt0 ? req0_im_b : gnt1 ? req1_im_b : '0;
    mul_conj_d   = gnt0 ? req0_conj : gnt1 & req1_conj;
    tv_d         = {tv_q[S-2:0], xfer};
    tid_d        = {tid_q[S-2:0], gnt1};
    res0_valid_d = tv_q[S-1] & ~tid_q[S-1];
    res1_valid_d = tv_q[S-1] & tid_q[S-1];
    res0_re_d    = res0_valid_d ? mul_re_i : res0_re_q;
    res0_im_d    = res0_valid_d ? mul_im_i : res0_im_q;
    res1_re_d    = res1_valid_d ? mul_re_i : res1_re_q;
    res1_im_d    = res1_valid_d ? mul_im_i : res1_im_q;
    cnt0_d       = cnt0_q + {15'd0, gnt0 & ~&cnt0_q};
    cnt1_d       = cnt1_q + {15'd0, gnt1 & ~&cnt1_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= 1'b0;
      mul_re_a_q   <= '0;
      mul_im_a_q   <= '0;
      mul_re_b_q   <= '0;
      mul_im_b_q   <= '0;
      mul_conj_q   <= 1'b0;
      tv_q         <= '0;
      tid_q        <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_re_q    <= '0;
      res0_im_q    <= '0;
      res1_re_q    <= '0;
      res1_im_q    <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mul_re_a_q   <= mul_re_a_d;
      mul_im_a_q   <= mul_im_a_d;
      mul_re_b_q   <= mul_re_b_d;
      mul_im_b_q   <= mul_im_b_d;
      mul_conj_q   <= mul_conj_d;
      tv_q         <= tv_d;
      tid_q        <= tid_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_re_q    <= res0_re_d;
      res0_im_q    <= res0_im_d;
      res1_re_q    <= res1_re_d;
      res1_im_q    <= res1_im_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_re_a   = mul_re_a_q;
  assign mul_im_a   = mul_im_a_q;
  assign mul_re_b   = mul_re_b_q;
  assign mul_im_b   = mul_im_b_q;
  assign mul_conj   = mul_conj_q;
  assign res0_valid = res0_valid_q;
  assign res0_re    = res0_re_q;
  assign res0_im    = res0_im_q;
  assign res1_valid = res1_valid_q;
  assign res1_re    = res1_re_q;
  assign res1_im    = res1_im_q;
  assign busy       = |tv_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_cmult_scheduler.sv
// tb_cmult_scheduler: directed + random stimulus against a queue-based reference model,
// with a behavioural fixed-latency saturating complex multiplier attached to mul_*.
module tb_cmult_scheduler;
  localparam int W = 16;
  localparam int L = 4;
  logic clk = 0, rst_n = 0, sched_en = 0;
  logic req0_valid = 0, req0_conj = 0, req1_valid = 0, req1_conj = 0;
  logic [W-1:0] req0_re_a = 0, req0_im_a = 0, req0_re_b = 0, req0_im_b = 0;
  logic [W-1:0] req1_re_a = 0, req1_im_a = 0, req1_re_b = 0, req1_im_b = 0;
  logic req0_ready, req1_ready, mul_conj, res0_valid, res1_valid, busy;
  logic [W-1:0] mul_re_a, mul_im_a, mul_re_b, mul_im_b, mul_re_i, mul_im_i;
  logic [W-1:0] res0_re, res0_im, res1_re, res1_im;
  logic [15:0] grant_cnt0, grant_cnt1;
  cmult_scheduler #(.DATAWIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_re_a(req0_re_a), .req0_im_a(req0_im_a),
    .req0_re_b(req0_re_b), .req0_im_b(req0_im_b), .req0_conj(req0_conj),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_re_a(req1_re_a), .req1_im_a(req1_im_a),
    .req1_re_b(req1_re_b), .req1_im_b(req1_im_b), .req1_conj(req1_conj),
    .mul_re_a(mul_re_a), .mul_im_a(mul_im_a), .mul_re_b(mul_re_b), .mul_im_b(mul_im_b),
    .mul_conj(mul_conj), .mul_re_i(mul_re_i), .mul_im_i(mul_im_i),
    .res0_valid(res0_valid), .res0_re(res0_re), .res0_im(res0_im),
    .res1_valid(res1_valid), .res1_re(res1_re), .res1_im(res1_im),
    .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [W-1:0] sat(input longint v);
    longint s = v >>> 15;
    return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : s[15:0];
  endfunction
  task automatic cm(input logic [W-1:0] ar, ai, br, bi, input logic c, output logic [W-1:0] re, im);
    longint a_r = longint'($signed(ar)), a_i = longint'($signed(ai));
    longint b_r = longint'($signed(br)), b_i = longint'($signed(bi));
    re = sat(c ? a_r * b_r + a_i * b_i : a_r * b_r - a_i * b_i);
    im = sat(c ? a_i * b_r - a_r * b_i : a_i * b_r + a_r * b_i);
  endtask
  logic [W-1:0] pre[L], pim[L];
  always @(posedge clk) begin
    logic [W-1:0] r, i;
    cm(mul_re_a, mul_im_a, mul_re_b, mul_im_b, mul_conj, r, i);
    pre[0] <= r;
    pim[0] <= i;
    for (int k = 1; k < L; k++) begin
      pre[k] <= pre[k-1];
      pim[k] <= pim[k-1];
    end
  end
  assign mul_re_i = pre[L-1];
  assign mul_im_i = pim[L-1];
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  typedef struct { logic [W-1:0] re, im; int due; } exp_t;
  exp_t q0[$], q1[$];
  logic ptr_m = 0, t0 = 0, t1 = 0;
  int cnt0_m = 0, cnt1_m = 0;
  logic [64:0] mul_m = 0;
  always @(negedge clk) begin
    logic e0, e1, b, x0, x1;
    logic [W-1:0] r, i;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      ptr_m = 0; cnt0_m = 0; cnt1_m = 0; t0 = 0; t1 = 0; mul_m = 0;
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_res_valid", {res0_valid, res1_valid}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul", {mul_re_a, mul_im_a, mul_re_b, mul_im_b}, 0);
      chk("rst_res", {res0_re, res0_im, res1_re, res1_im}, 0);
      chk("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
    end else begin
      e0 = sched_en & req0_valid & (!req1_valid | !ptr_m);
      e1 = sched_en & req1_valid & (!req0_valid | ptr_m);
      chk("ready", {req0_ready, req1_ready}, {e0, e1});
      chk("mul_ops", {mul_conj, mul_re_a, mul_im_a, mul_re_b, mul_im_b}, mul_m);
      while (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
      while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
      b = 0;
      foreach (q0[k]) if (q0[k].due - L - 1 <= cyc && cyc <= q0[k].due - 1) b = 1;
      foreach (q1[k]) if (q1[k].due - L - 1 <= cyc && cyc <= q1[k].due - 1) b = 1;
      chk("busy", busy, b);
      x0 = q0.size() > 0 && q0[0].due == cyc;
      x1 = q1.size() > 0 && q1[0].due == cyc;
      chk("res0_valid", res0_valid, x0);
      chk("res1_valid", res1_valid, x1);
      if (x0) begin
        chk("res0_data", {res0_re, res0_im}, {q0[0].re, q0[0].im});
        void'(q0.pop_front());
      end
      if (x1) begin
        chk("res1_data", {res1_re, res1_im}, {q1[0].re, q1[0].im});
        void'(q1.pop_front());
      end
      chk("grant_cnt", {grant_cnt0, grant_cnt1}, {cnt0_m[15:0], cnt1_m[15:0]});
      t0 = e0; t1 = e1; mul_m = 0;
      if (e0) begin
        cm(req0_re_a, req0_im_a, req0_re_b, req0_im_b, req0_conj, r, i);
        q0.push_back('{r, i, cyc + L + 2});
        if (cnt0_m < 65535) cnt0_m++;
        ptr_m = 1;
        mul_m = {req0_conj, req0_re_a, req0_im_a, req0_re_b, req0_im_b};
      end
      if (e1) begin
        cm(req1_re_a, req1_im_a, req1_re_b, req1_im_b, req1_conj, r, i);
        q1.push_back('{r, i, cyc + L + 2});
        if (cnt1_m < 65535) cnt1_m++;
        ptr_m = 0;
        mul_m = {req1_conj, req1_re_a, req1_im_a, req1_re_b, req1_im_b};
      end
    end
  end
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rnd(input int n, input int p0, input int p1, input bit en);
    repeat (n) begin
      sched_en = en;
      if (!(req0_valid && !t0)) begin
        req0_valid = $urandom_range(99) < p0;
        req0_re_a = $urandom; req0_im_a = $urandom; req0_re_b = $urandom; req0_im_b = $urandom;
        req0_conj = $urandom;
      end
      if (!(req1_valid && !t1)) begin
        req1_valid = $urandom_range(99) < p1;
        req1_re_a = $urandom; req1_im_a = $urandom; req1_re_b = $urandom; req1_im_b = $urandom;
        req1_conj = $urandom;
      end
      go(1);
    end
  endtask
  initial begin
    go(2);
    rst_n = 1; sched_en = 1;
    req0_valid = 1; req0_re_a = 16'h4000; req0_im_a = 0; req0_re_b = 16'h4000; req0_im_b = 0; req0_conj = 0;
    go(1);
    req0_valid = 0;
    go(8);
    chk("single_res0", {res0_re, res0_im}, {16'h2000, 16'h0000});
    req1_valid = 1; req1_re_a = 0; req1_im_a = 16'h4000; req1_re_b = 0; req1_im_b = 16'h4000; req1_conj = 1;
    go(1);
    req1_valid = 0;
    go(8);
    chk("conj1_res1", {res1_re, res1_im}, {16'h2000, 16'h0000});
    req1_valid = 1; req1_conj = 0;
    go(1);
    req1_valid = 0;
    go(8);
    chk("conj0_res1", {res1_re, res1_im}, {16'he000, 16'h0000});
    rst_n = 0;
    go(1);
    rst_n = 1;
    rnd(8, 100, 100, 1);
    req0_valid = 0; req1_valid = 0;
    go(10);
    chk("contention_cnt", {grant_cnt0, grant_cnt1}, {16'd4, 16'd4});
    rnd(2, 100, 0, 1);
    rnd(4, 100, 0, 0);
    req0_valid = 0; sched_en = 1;
    go(10);
    chk("en_drop_busy", busy, 0);
    for (int k = 0; k < 20; k++) rnd(20, 60, 60, $urandom_range(3) != 0);
    rnd(3, 100, 100, 1);
    rst_n = 0;
    go(1);
    rst_n = 1; req0_valid = 0; req1_valid = 0;
    go(10);
    chk("midrst_state", {busy, grant_cnt0, grant_cnt1}, 0);
    req0_valid = 1; req1_valid = 1;
    go(1);
    req0_valid = 0; req1_valid = 0;
    chk("midrst_ptr_cnt", {grant_cnt0, grant_cnt1}, {16'd1, 16'd0});
    go(10);
    rnd(65540, 100, 0, 1);
    req0_valid = 0;
    go(10);
    chk("sat_cnt0", grant_cnt0, 16'hffff);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmult_scheduler.md
CMULT_SCHEDULER -- requirements
Module: cmult_scheduler

Interface
REQ-001 Parameter DATAWIDTH, default 16, operand/result component width, signed Q0.15.
REQ-002 Parameter LATENCY, default 4, fixed multiplier latency in cycles, range 1..8.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 sched_en  in  1  1 = grants allowed; 0 = no new grants.
REQ-006 reqN_valid  in  1  requester N (N=0,1) operand pair valid.
REQ-007 reqN_ready  out  1  grant to requester N; a transfer occurs when valid and ready are both 1.
REQ-008 reqN_re_a, reqN_im_a, reqN_re_b, reqN_im_b  in  DATAWIDTH each  operands A and B.
REQ-009 reqN_conj  in  1  1 = multiply by conj(B).
REQ-010 mul_re_a, mul_im_a, mul_re_b, mul_im_b  out  DATAWIDTH each  registered operands to the shared multiplier.
REQ-011 mul_conj  out  1  registered conjugate flag to the multiplier.
REQ-012 mul_re_i, mul_im_i  in  DATAWIDTH each  multiplier result, saturated Q0.15.
REQ-013 resN_valid  out  1  one-cycle strobe: result for requester N.
REQ-014 resN_re, resN_im  out  DATAWIDTH each  result for requester N.
REQ-015 busy  out  1  1 while any issued operation has not yet been delivered.
REQ-016 grant_cntN  out  16  saturating count of transfers accepted from requester N.

Function
REQ-017 At most one transfer per cycle; reqN_ready is combinational from reqN_valid, sched_en and the priority pointer.
REQ-018 Arbitration: only one requester valid -> that requester is granted; both valid -> the requester selected by the priority pointer is granted; sched_en=0 -> both ready=0.
REQ-019 Priority pointer is 1 bit, resets to 0 (requester 0), and points to the other requester after every transfer (round-robin); it holds when no transfer occurs.
REQ-020 On a transfer, the selected operands and conj are registered onto mul_* at that edge; with no transfer, mul_* operands and mul_conj are registered to 0.
REQ-021 The multiplier contract is: operands on mul_* during cycle k produce their result on mul_re_i/mul_im_i during cycle k+LATENCY; the multiplier has no stall.
REQ-022 A tag pipeline of LATENCY+1 stages, each {valid, id}, tracks every issued operation in step with the multiplier.
REQ-023 When the final tag stage is valid with id N, resN_re/resN_im register mul_re_i/mul_im_i and resN_valid=1 for exactly one cycle.
REQ-024 The other requester's resN_valid is 0; res data holds its last value when not valid.
REQ-025 Latency: a transfer in cycle c produces resN_valid=1 in cycle c+LATENCY+2 (c+6 at default).
REQ-026 Results per requester are delivered in issue order; throughput is one result per cycle, and there is no result backpressure.
REQ-027 busy = OR of all tag-stage valid bits.
REQ-028 Deasserting sched_en mid-stream blocks new grants only; in-flight operations still complete and deliver.
REQ-029 A requester holding valid with ready=0 keeps its operands stable; the scheduler never drops a granted transfer.
REQ-030 grant_cntN increments on each transfer from N and stops at 16'hFFFF.

Reset
REQ-031 While rst_n=0: all ready, resN_valid and busy are 0; mul_* and res data are 0; tag pipeline is cleared; pointer is 0; counters are 0.
REQ-032 Reset asserted mid-operation discards all in-flight results; no resN_valid is produced for operations issued before reset.
REQ-033 After rst_n deasserts, the first grant is possible on the first rising edge.

Verification
REQ-034 Single operation: req0 (0.5, 0)x(0.5, 0) = 16'h4000 components, conj=0, in cycle 0 -> res0_valid in cycle 6 with res0_re=16'h2000, res0_im=0; res1_valid stays 0.
REQ-035 Contention: req0 and req1 valid continuously for 8 cycles -> grants alternate 0,1,0,1...; each grant_cntN=4; results return alternating, one per cycle.
REQ-036 Conjugate: A=(0,0.5), B=(0,0.5), conj=1 on req1 -> res1_re=16'h2000, res1_im=0; with conj=0 -> res1_re=16'hE000.
REQ-037 sched_en dropped two cycles after a stream starts -> ready=0 immediately; both issued results still arrive; busy falls 0 after the last result.
REQ-038 rst_n pulsed low for 1 cycle with 3 operations in flight -> no resN_valid afterward, busy=0, grant_cnt0 and grant_cnt1=0, pointer=0.
REQ-039 Counter saturation: force 65,540 req0 transfers -> grant_cnt0 holds 16'hFFFF.
